// File: rtl/branch_pkg.sv
//==============================================================================
// Module      : branch_pkg
// Description : Shared op and FSM state encodings for the branch resolver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package branch_pkg;

    localparam logic [1:0] OP_BEQ = 2'b00;
    localparam logic [1:0] OP_BNE = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_CMP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_ctrl_if.sv
//==============================================================================
// Module      : branch_resolve_ctrl_if
// Description : Request/response bundle between a requester and the resolver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface branch_resolve_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_pc4;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [15:0]      req_offset;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_taken;
    logic [31:0]      resp_next_pc;
    logic             resp_illegal;
    logic             flush;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output req_valid, req_op, req_pc4, req_a, req_b, req_offset, resp_ready,
        input  req_ready, resp_valid, resp_taken, resp_next_pc, resp_illegal,
               flush, taken_count
    );

    modport slave (
        input  req_valid, req_op, req_pc4, req_a, req_b, req_offset, resp_ready,
        output req_ready, resp_valid, resp_taken, resp_next_pc, resp_illegal,
               flush, taken_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_target_adder.sv
//==============================================================================
// Module      : branch_target_adder
// Description : Branch target = pc4 + (sign-extended word offset << 2), mod 2^32.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_target_adder (
    input  wire logic [31:0] i_pc4,
    input  wire logic [15:0] i_offset,
    output logic      [31:0] o_target
);

    logic [31:0] w_byte_offset;

    assign w_byte_offset = {{14{i_offset[15]}}, i_offset, 2'b00};
    assign o_target      = i_pc4 + w_byte_offset;

endmodule

`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
//==============================================================================
// Module      : branch_resolve_ctrl
// Description : Multi-cycle BEQ/BNE resolver with flush pulse and taken counter.
//               Define BRANCH_BNE_EN to resolve op 01 as BNE (else reserved).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    branch_resolve_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [31:0]      r_pc4;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [15:0]      r_offset;
    logic [31:0]      r_target;
    logic             r_taken;
    logic [31:0]      r_next_pc;
    logic             r_illegal;
    logic             r_flush;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      w_target;
    logic             w_zero;
    logic             w_legal;
    logic             w_taken;
    logic             w_req_ready;
    logic             w_resp_valid;

    branch_target_adder u_target_adder (
        .i_pc4    (r_pc4),
        .i_offset (r_offset),
        .o_target (w_target)
    );

    always_comb begin
        w_zero = (r_a == r_b);
`ifdef BRANCH_BNE_EN
        w_legal = (r_op == OP_BEQ) || (r_op == OP_BNE);
`else
        w_legal = (r_op == OP_BEQ);
`endif
        w_taken = w_legal && ((r_op == OP_BEQ) ? w_zero : !w_zero);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_state_nxt = S_CALC;
            end
            S_CALC: w_state_nxt = S_CMP;
            S_CMP:  w_state_nxt = S_RESP;
            S_RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Response fields only change on the CMP->RESP step, so they hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= 2'b00;
            r_pc4     <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_offset  <= 16'd0;
            r_target  <= 32'd0;
            r_taken   <= 1'b0;
            r_next_pc <= 32'd0;
            r_illegal <= 1'b0;
            r_flush   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_flush <= (r_state == S_CMP) && w_taken;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op     <= bus.req_op;
                        r_pc4    <= bus.req_pc4;
                        r_a      <= bus.req_a;
                        r_b      <= bus.req_b;
                        r_offset <= bus.req_offset;
                    end
                end
                S_CALC: r_target <= w_target;
                S_CMP: begin
                    r_taken   <= w_taken;
                    r_illegal <= !w_legal;
                    r_next_pc <= w_taken ? r_target : r_pc4;
                    if (w_taken && (r_count != {CNT_W{1'b1}})) begin
                        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.resp_valid   = w_resp_valid;
    assign bus.resp_taken   = r_taken;
    assign bus.resp_next_pc = r_next_pc;
    assign bus.resp_illegal = r_illegal;
    assign bus.flush        = r_flush;
    assign bus.taken_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
//==============================================================================
// Module      : tb_branch_resolve_ctrl
// Description : Scoreboard bench for branch_resolve_ctrl (CNT_W=16 and CNT_W=2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_resolve_ctrl;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_pc4 = 32'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [15:0] req_offset = 16'd0;
    logic        resp_ready = 1'b1;

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.CNT_W(16)) bus0 ();
    branch_resolve_ctrl_if #(.CNT_W(2))  bus1 ();

    assign bus0.req_valid  = req_valid;
    assign bus0.req_op     = req_op;
    assign bus0.req_pc4    = req_pc4;
    assign bus0.req_a      = req_a;
    assign bus0.req_b      = req_b;
    assign bus0.req_offset = req_offset;
    assign bus0.resp_ready = resp_ready;
    assign bus1.req_valid  = req_valid;
    assign bus1.req_op     = req_op;
    assign bus1.req_pc4    = req_pc4;
    assign bus1.req_a      = req_a;
    assign bus1.req_b      = req_b;
    assign bus1.req_offset = req_offset;
    assign bus1.resp_ready = resp_ready;

    branch_resolve_ctrl #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus0));
    branch_resolve_ctrl #(.CNT_W(2))  u_dut_small (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic        taken;
        logic [31:0] next_pc;
        logic        illegal;
        logic [15:0] cnt16;
        logic [1:0]  cnt2;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m16 = 0;
    int   m2 = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response, then checks it holds steady.
    always @(negedge clk) begin
        if (!rst && bus0.resp_valid) begin
            if (!prev_v) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected none");
                end else begin
                    cur = q.pop_front();
                    chk("taken", 32'(bus0.resp_taken), 32'(cur.taken));
                    chk("next_pc", bus0.resp_next_pc, cur.next_pc);
                    chk("illegal", 32'(bus0.resp_illegal), 32'(cur.illegal));
                    chk("flush_first", 32'(bus0.flush), 32'(cur.taken));
                    chk("count16", 32'(bus0.taken_count), 32'(cur.cnt16));
                    chk("count2", 32'(bus1.taken_count), 32'(cur.cnt2));
                    chk("small_taken", 32'(bus1.resp_taken), 32'(cur.taken));
                    chk("small_next_pc", bus1.resp_next_pc, cur.next_pc);
                    chk("small_illegal", 32'(bus1.resp_illegal), 32'(cur.illegal));
                    chk("small_flush", 32'(bus1.flush), 32'(cur.taken));
                    chk("latency", 32'(cyc - cur.acc), 32'd3);
                end
            end else begin
                chk("hold_taken", 32'(bus0.resp_taken), 32'(cur.taken));
                chk("hold_next_pc", bus0.resp_next_pc, cur.next_pc);
                chk("hold_illegal", 32'(bus0.resp_illegal), 32'(cur.illegal));
                chk("hold_flush", 32'(bus0.flush), 32'd0);
                chk("hold_req_ready", 32'(bus0.req_ready), 32'd0);
                chk("hold_small_ready", 32'(bus1.req_ready), 32'd0);
            end
        end else begin
            chk("idle_flush", 32'(bus0.flush), 32'd0);
        end
        prev_v <= bus0.resp_valid;
    end

    task automatic send(input logic [1:0] op, input logic [31:0] pc4, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] off, input logic exp_taken,
                        input logic [31:0] exp_pc, input logic exp_ill);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        req_op = op; req_pc4 = pc4; req_a = a; req_b = b; req_offset = off;
        req_valid = 1'b1;
        n = 0;
        while (!bus0.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus0.req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
            req_valid = 1'b0;
            return;
        end
        if (exp_taken) begin
            if (m16 != 65535) m16++;
            if (m2 != 3) m2++;
        end
        e.taken = exp_taken; e.next_pc = exp_pc; e.illegal = exp_ill;
        e.cnt16 = 16'(m16); e.cnt2 = 2'(m2); e.acc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus0.req_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(bus0.req_ready), 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
        chk("rst_taken", 32'(bus0.resp_taken), 32'd0);
        chk("rst_next_pc", bus0.resp_next_pc, 32'd0);
        chk("rst_illegal", 32'(bus0.resp_illegal), 32'd0);
        chk("rst_flush", 32'(bus0.flush), 32'd0);
        chk("rst_count", 32'(bus0.taken_count), 32'd0);
        rst = 1'b0;

        // Abandon an in-flight branch by resetting while in CALC.
        @(posedge clk); #1;
        req_op = OP_BEQ; req_pc4 = 32'h0000_1004; req_a = 32'd7; req_b = 32'd7;
        req_offset = 16'h0003; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("calc_req_ready", 32'(bus0.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("abort_resp_valid", 32'(bus0.resp_valid), 32'd0);
        chk("abort_flush", 32'(bus0.flush), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_count", 32'(bus0.taken_count), 32'd0);

        send(OP_BEQ, 32'h0000_1004, 32'd5, 32'd5, 16'h0003, 1'b1, 32'h0000_1010, 1'b0);
        wait_idle();
        send(OP_BEQ, 32'h0000_1004, 32'd5, 32'd6, 16'hFFFF, 1'b0, 32'h0000_1004, 1'b0);
        wait_idle();
        send(OP_BEQ, 32'hFFFF_FFFC, 32'h1234, 32'h1234, 16'h0002, 1'b1, 32'h0000_0004, 1'b0);
        wait_idle();
`ifdef BRANCH_BNE_EN
        send(2'b01, 32'h0000_2000, 32'd1, 32'd2, 16'h0010, 1'b1, 32'h0000_2040, 1'b0);
`else
        send(2'b01, 32'h0000_2000, 32'd1, 32'd2, 16'h0010, 1'b0, 32'h0000_2000, 1'b1);
`endif
        wait_idle();

        // Back-pressure: resp_ready held low for 5 cycles of RESP.
        resp_ready = 1'b0;
        send(OP_BEQ, 32'h0000_3000, 32'd9, 32'd9, 16'hFFFC, 1'b1, 32'h0000_2FF0, 1'b0);
        n = 0;
        while (!bus0.resp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_resp_valid", 32'(bus0.resp_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_idle();

        send(2'b10, 32'h0000_4000, 32'd3, 32'd3, 16'h0001, 1'b0, 32'h0000_4000, 1'b1);
        wait_idle();
        send(2'b11, 32'h0000_5000, 32'd3, 32'd4, 16'h0001, 1'b0, 32'h0000_5000, 1'b1);
        wait_idle();
        send(OP_BEQ, 32'h0000_6000, 32'd0, 32'd0, 16'h0000, 1'b1, 32'h0000_6000, 1'b0);
        wait_idle();
        send(OP_BEQ, 32'h0000_7000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h8000, 1'b1,
             32'hFFFE_7000, 1'b0);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef BRANCH_BNE_EN
        chk("final_count16", 32'(bus0.taken_count), 32'd6);
`else
        chk("final_count16", 32'(bus0.taken_count), 32'd5);
`endif
        chk("final_count2_sat", 32'(bus1.taken_count), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the taken-branch counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, branch request present.
REQ-005 SHALL have port req_ready, output, 1, the block accepts a request this cycle.
REQ-006 SHALL have port req_op, input, 2, operation: 00 BEQ, 01 BNE, 10/11 reserved.
REQ-007 SHALL have port req_pc4, input, 32, address of the branch instruction plus 4.
REQ-008 SHALL have ports req_a and req_b, input, 32 each, the comparison operands.
REQ-009 SHALL have port req_offset, input, 16, the signed word offset from the instruction.
REQ-010 SHALL have port resp_valid, output, 1, resolution result present.
REQ-011 SHALL have port resp_ready, input, 1, the consumer accepts the result.
REQ-012 SHALL have port resp_taken, output, 1, the branch is taken.
REQ-013 SHALL have port resp_next_pc, output, 32, target if taken, else req_pc4.
REQ-014 SHALL have port resp_illegal, output, 1, a reserved or disabled op was received.
REQ-015 SHALL have port flush, output, 1, one-cycle pulse requesting a fetch-stage flush.
REQ-016 SHALL have port taken_count, output, CNT_W, a saturating count of taken branches.

Function
REQ-017 SHALL implement the FSM states IDLE, CALC, CMP and RESP.
REQ-018 SHALL assert req_ready only in IDLE; on req_valid&&req_ready, SHALL capture all req_* fields into registers and go to CALC.
REQ-019 In CALC, SHALL register target = req_pc4 + (sign-extended offset << 2), computed modulo 2^32 with wrap-around and no overflow flag, then go to CMP.
REQ-020 In CMP, SHALL register zero = (A == B), evaluate taken (BEQ: zero; BNE: !zero), set resp fields, then go to RESP.
REQ-021 In RESP, SHALL hold resp_valid high and keep all resp_* fields stable until resp_ready is sampled high.
REQ-022 On the RESP handshake, SHALL return to IDLE; req_ready SHALL be high on the following cycle, giving a minimum of 4 cycles per branch.
REQ-023 SHALL pulse flush for exactly one cycle: the cycle resp_valid first rises, and only when resp_taken is 1.
REQ-024 SHALL increment taken_count on the CMP-to-RESP transition when taken, saturating at all-ones.
REQ-025 For a reserved op, SHALL set resp_illegal=1 and resp_taken=0 and resp_next_pc=req_pc4, with no flush and no count.
REQ-026 SHALL ignore req_valid outside IDLE; requesters SHALL hold requests until req_ready is high.
REQ-027 SHALL drive resp_valid=0 in all states other than RESP, with resp_* fields holding their last values.

Reset
REQ-028 rst SHALL asynchronously force IDLE, req_ready=1 once rst is released, resp_valid=0, resp_taken=0, resp_next_pc=0, resp_illegal=0, flush=0 and taken_count=0.
REQ-029 Reset asserted mid-operation SHALL abandon the in-flight branch with no response, no flush and no count.

Configuration
REQ-030 With BRANCH_BNE_EN defined, op 01 SHALL resolve as BNE.
REQ-031 With BRANCH_BNE_EN undefined, op 01 SHALL be treated as reserved per REQ-025.

Structure
REQ-032 SHALL place the op encodings (OP_BEQ, OP_BNE) and the FSM state encodings in the shared package branch_pkg.
REQ-033 SHALL isolate the sign-extend, shift and add in one sub-module, branch_target_adder; the compare and FSM SHALL stay in the top module.

Verification
REQ-034 SHALL verify: BEQ, pc4=0x0000_1004, A=B=5, offset=0x0003, resp_ready=1 -> taken=1, next_pc=0x0000_1010, one flush pulse, count=1, response 3 cycles after acceptance.
REQ-035 SHALL verify: BEQ, pc4=0x0000_1004, A=5, B=6, offset=0xFFFF -> taken=0, next_pc=0x0000_1004, no flush, count unchanged.
REQ-036 SHALL verify: BEQ, pc4=0xFFFF_FFFC, A=B, offset=0x0002 -> next_pc=0x0000_0004 (wrap-around).
REQ-037 SHALL verify: op=01, A=1, B=2 -> with BRANCH_BNE_EN, taken=1; without it, illegal=1 and taken=0.
REQ-038 SHALL verify: resp_ready held low for 5 cycles -> resp fields stable, flush only on the first cycle, req_ready=0 throughout.
REQ-039 SHALL verify: rst asserted in CALC -> immediate IDLE, no resp_valid; CNT_W=2 with 5 taken branches -> taken_count=3.
